// File: rtl/ss_master.sv
// rtl/ss_master.sv - save-state bus initiator: walks ssbus slaves to save/load a 64-bit memory image
module ss_master #(
  parameter int N_SLAVES = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_save,
  input  logic        start_load,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [7:0]  ssbus_select,
  output logic [23:0] ssbus_addr,
  output logic [63:0] ssbus_data,
  output logic        ssbus_query,
  output logic        ssbus_read,
  output logic        ssbus_write,
  input  logic        ssbus_ack,
  input  logic [63:0] ssbus_data_out,
  input  logic [31:0] ssbus_count
);

  typedef enum logic [3:0] {
    IDLE, S_QUERY, S_HDR, S_RD, S_WR, S_NEXT, S_END, L_HDR, L_RD, L_WR, DONE, ERR
  } state_t;

  localparam logic [63:0] MARKER   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [8:0]  LAST_IDX = 9'(N_SLAVES - 1);
  localparam logic [8:0]  NS9      = 9'(N_SLAVES);
  localparam logic [31:0] TMO      = 32'(TIMEOUT);

  state_t      state, state_next;
  logic [8:0]  idx;
  logic [31:0] count;
  logic [31:0] k;
  logic [63:0] word;
  logic [31:0] tcnt;

  logic last_word;
  logic ss_timeout;
  logic hdr_bad;

  assign last_word  = (k == count - 32'd1);
  // ack in the same cycle as the expiry still counts as success
  assign ss_timeout = (tcnt == TMO) && !ssbus_ack;
  assign hdr_bad    = (mem_rdata[63:48] != 16'h5353) ||
                      ({1'b0, mem_rdata[39:32]} >= NS9) ||
                      (mem_rdata[31:0] > 32'h0100_0000);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state and strobe decode; all outputs are a function of state so reset clears them at once
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = 64'd0;
    ssbus_select = 8'd0;
    ssbus_addr   = 24'd0;
    ssbus_data   = 64'd0;
    ssbus_query  = 1'b0;
    ssbus_read   = 1'b0;
    ssbus_write  = 1'b0;
    case (state)
      IDLE: begin
        if (start_save)      state_next = S_QUERY;
        else if (start_load) state_next = L_HDR;
      end
      S_QUERY: begin
        busy         = 1'b1;
        ssbus_query  = 1'b1;
        ssbus_select = idx[7:0];
        if (ssbus_ack)       state_next = (ssbus_count == 32'd0) ? S_NEXT : S_HDR;
        else if (ss_timeout) state_next = S_NEXT;
      end
      S_HDR: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = {16'h5353, 8'h00, idx[7:0], count};
        if (mem_ack) state_next = S_RD;
      end
      S_RD: begin
        busy         = 1'b1;
        ssbus_read   = 1'b1;
        ssbus_select = idx[7:0];
        ssbus_addr   = k[23:0];
        if (ssbus_ack)       state_next = S_WR;
        else if (ss_timeout) state_next = ERR;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = word;
        if (mem_ack) state_next = last_word ? S_NEXT : S_RD;
      end
      S_NEXT: begin
        busy       = 1'b1;
        state_next = (idx == LAST_IDX) ? S_END : S_QUERY;
      end
      S_END: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = MARKER;
        if (mem_ack) state_next = DONE;
      end
      L_HDR: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          if (mem_rdata == MARKER)           state_next = DONE;
          else if (hdr_bad)                  state_next = ERR;
          else if (mem_rdata[31:0] == 32'd0) state_next = L_HDR;
          else                               state_next = L_RD;
        end
      end
      L_RD: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) state_next = L_WR;
      end
      L_WR: begin
        busy         = 1'b1;
        ssbus_write  = 1'b1;
        ssbus_select = idx[7:0];
        ssbus_addr   = k[23:0];
        ssbus_data   = word;
        if (ssbus_ack)       state_next = last_word ? L_HDR : L_RD;
        else if (ss_timeout) state_next = ERR;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // walk counters, captured words, image address and the sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= 9'd0;
      count    <= 32'd0;
      k        <= 32'd0;
      word     <= 64'd0;
      mem_addr <= 32'd0;
      error    <= 1'b0;
    end else begin
      if (mem_req && mem_ack) mem_addr <= mem_addr + 32'd8;
      if (state_next == ERR && state != ERR) error <= 1'b1;
      case (state)
        IDLE: if (start_save || start_load) begin
          mem_addr <= {base_addr[31:3], 3'b000};
          idx      <= 9'd0;
          k        <= 32'd0;
          error    <= 1'b0;
        end
        S_QUERY: if (ssbus_ack) begin
          count <= ssbus_count;
          k     <= 32'd0;
        end
        S_RD:   if (ssbus_ack) word <= ssbus_data_out;
        S_WR:   if (mem_ack && !last_word) k <= k + 32'd1;
        S_NEXT: idx <= idx + 9'd1;
        L_HDR: if (mem_ack) begin
          idx   <= {1'b0, mem_rdata[39:32]};
          count <= mem_rdata[31:0];
          k     <= 32'd0;
        end
        L_RD:   if (mem_ack) word <= mem_rdata;
        L_WR:   if (ssbus_ack && !last_word) k <= k + 32'd1;
        default: ;
      endcase
    end
  end

  // ack-wait counter restarts on every state change, i.e. whenever a new strobe rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    tcnt <= 32'd0;
    else if (state_next != state) tcnt <= 32'd0;
    else if (tcnt != TMO)         tcnt <= tcnt + 32'd1;
  end

endmodule

// File: tb/tb_ss_master.sv
// tb/tb_ss_master.sv - scoreboard bench for ss_master with memory and ssbus slave models
module tb_ss_master;
  localparam int NS = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset, start_save, start_load;
  logic [31:0] base_addr;
  logic        busy, done, error;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  ssbus_select;
  logic [23:0] ssbus_addr;
  logic [63:0] ssbus_data, ssbus_data_out;
  logic        ssbus_query, ssbus_read, ssbus_write, ssbus_ack;
  logic [31:0] ssbus_count;

  always #5 clk = ~clk;

  ss_master #(.N_SLAVES(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start_save(start_save), .start_load(start_load),
    .base_addr(base_addr), .busy(busy), .done(done), .error(error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ssbus_select(ssbus_select), .ssbus_addr(ssbus_addr), .ssbus_data(ssbus_data),
    .ssbus_query(ssbus_query), .ssbus_read(ssbus_read), .ssbus_write(ssbus_write),
    .ssbus_ack(ssbus_ack), .ssbus_data_out(ssbus_data_out), .ssbus_count(ssbus_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [95:0] exp_mem_q[$], obs_mem_q[$], exp_ss_q[$], obs_ss_q[$];
  logic [63:0] mem [logic [31:0]];
  logic [31:0] slave_count [NS];
  logic [63:0] slave_data [NS][16];
  logic        noack_q [NS];
  logic        noack_r [NS];
  int done_cnt, mem_wr_cnt, ss_wr_cnt, rd_hi, q2_hi, onehot_bad;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // memory model: acks every other cycle while mem_req is held
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 64'd0;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_ack) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          obs_mem_q.push_back({mem_addr, mem_wdata});
          mem_wr_cnt++;
        end else begin
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  // slave model: register file per slave with optional silent query/read
  initial begin
    ssbus_ack = 1'b0;
    ssbus_data_out = 64'd0;
    ssbus_count = 32'd0;
    forever begin
      @(negedge clk);
      if ((ssbus_query || ssbus_read || ssbus_write) && !ssbus_ack && int'(ssbus_select) < NS &&
          !(ssbus_query && noack_q[ssbus_select]) && !(ssbus_read && noack_r[ssbus_select])) begin
        ssbus_ack = 1'b1;
        if (ssbus_query) ssbus_count = slave_count[ssbus_select];
        if (ssbus_read)  ssbus_data_out = slave_data[ssbus_select][ssbus_addr[3:0]];
        if (ssbus_write) begin
          slave_data[ssbus_select][ssbus_addr[3:0]] = ssbus_data;
          obs_ss_q.push_back({ssbus_select, ssbus_addr, ssbus_data});
          ss_wr_cnt++;
        end
      end else begin
        ssbus_ack = 1'b0;
      end
    end
  end

  // activity counters sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (ssbus_read) rd_hi++;
    if (ssbus_query && ssbus_select == 8'd2) q2_hi++;
    if ($countones({ssbus_query, ssbus_read, ssbus_write}) > 1) onehot_bad++;
  end

  // scoreboard monitor: pairs every observed write with the oldest expected one
  initial forever begin
    logic [95:0] o;
    @(posedge clk);
    while (obs_mem_q.size() > 0) begin
      o = obs_mem_q.pop_front();
      if (exp_mem_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL mem_wr unexpected: got %0h, expected none", o);
      end else check("mem_wr", 128'(o), 128'(exp_mem_q.pop_front()));
    end
    while (obs_ss_q.size() > 0) begin
      o = obs_ss_q.pop_front();
      if (exp_ss_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL ss_wr unexpected: got %0h, expected none", o);
      end else check("ss_wr", 128'(o), 128'(exp_ss_q.pop_front()));
    end
  end

  task automatic clear_counts();
    done_cnt = 0; mem_wr_cnt = 0; ss_wr_cnt = 0; rd_hi = 0; q2_hi = 0;
  endtask

  task automatic push_img(logic [31:0] base, int cnt);
    exp_mem_q.push_back({base, 16'h5353, 8'h00, 8'h01, 32'(cnt)});
    for (int i = 0; i < cnt; i++) exp_mem_q.push_back({base + 32'(8 * (i + 1)), 64'(3 * i)});
    exp_mem_q.push_back({base + 32'(8 * (cnt + 1)), 64'hFFFF_FFFF_FFFF_FFFF});
  endtask

  task automatic start_op(string name, bit save, logic [31:0] base);
    @(negedge clk);
    base_addr = base;
    start_save = save;
    start_load = !save;
    @(posedge clk);
    #1;
    start_save = 1'b0;
    start_load = 1'b0;
    check({name, " busy_rise"}, 128'(busy), 128'(1));
    check({name, " first_strobe"}, 128'(save ? ssbus_query : (mem_req && !mem_we)), 128'(1));
    check({name, " error_cleared"}, 128'(error), 128'(0));
  endtask

  task automatic wait_end(string name);
    int n = 0;
    while (!(done || error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, " finished"}, 128'(n < 3000), 128'(1));
    repeat (4) @(negedge clk);
    check({name, " pending"}, 128'(exp_mem_q.size() + exp_ss_q.size()), 128'(0));
  endtask

  initial begin
    reset = 1'b1; start_save = 1'b0; start_load = 1'b0; base_addr = 32'd0;
    for (int s = 0; s < NS; s++) begin
      slave_count[s] = 32'd0; noack_q[s] = 1'b0; noack_r[s] = 1'b0;
      for (int a = 0; a < 16; a++) slave_data[s][a] = (s == 1) ? 64'(3 * a) : 64'd0;
    end
    clear_counts();
    onehot_bad = 0;
    repeat (2) @(negedge clk);
    check("rst strobes", 128'({busy, done, error, mem_req, mem_we, ssbus_query, ssbus_read, ssbus_write}), 128'(0));
    check("rst regs", 128'({mem_addr, mem_wdata, ssbus_data, ssbus_select, ssbus_addr}), 128'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // save: slave 1 holds 16 words of addr*3
    slave_count[1] = 32'd16;
    clear_counts();
    push_img(32'h1000, 16);
    start_op("save", 1'b1, 32'h1000);
    wait_end("save");
    check("save words", 128'(mem_wr_cnt), 128'(18));
    check("save done_pulses", 128'(done_cnt), 128'(1));
    check("save error", 128'({error, busy}), 128'(0));

    // load that image back into a cleared slave 1
    for (int a = 0; a < 16; a++) begin
      slave_data[1][a] = 64'd0;
      exp_ss_q.push_back({8'd1, 24'(a), 64'(3 * a)});
    end
    clear_counts();
    start_op("load", 1'b0, 32'h1000);
    wait_end("load");
    for (int a = 0; a < 16; a++) check("load slave_word", 128'(slave_data[1][a]), 128'(3 * a));
    check("load error", 128'(error), 128'(0));
    check("load done_pulses", 128'(done_cnt), 128'(1));

    // slave 2 never answers its query
    slave_count[1] = 32'd2;
    noack_q[2] = 1'b1;
    clear_counts();
    push_img(32'h2000, 2);
    start_op("skip", 1'b1, 32'h2000);
    wait_end("skip");
    check("skip error", 128'(error), 128'(0));
    check("skip query_wait", 128'(q2_hi == TO || q2_hi == TO + 1), 128'(1));
    check("skip done_pulses", 128'(done_cnt), 128'(1));
    noack_q[2] = 1'b0;

    // slave 1 never answers its read
    slave_count[1] = 32'd4;
    noack_r[1] = 1'b1;
    clear_counts();
    exp_mem_q.push_back({32'h3000, 64'h5353_0001_0000_0004});
    start_op("rdto", 1'b1, 32'h3000);
    wait_end("rdto");
    check("rdto error_busy", 128'({error, busy}), 128'(2'b10));
    check("rdto read_wait", 128'(rd_hi == TO || rd_hi == TO + 1), 128'(1));
    check("rdto no_marker", 128'(mem_wr_cnt), 128'(1));
    check("rdto done_pulses", 128'(done_cnt), 128'(0));
    noack_r[1] = 1'b0;

    // load with a corrupt header magic
    mem[32'h4000] = 64'h1234_0001_0000_0004;
    clear_counts();
    start_op("badhdr", 1'b0, 32'h4000);
    wait_end("badhdr");
    check("badhdr error", 128'(error), 128'(1));
    check("badhdr ss_writes", 128'(ss_wr_cnt), 128'(0));
    check("badhdr done_pulses", 128'(done_cnt), 128'(0));

    // reset while a read strobe is up, then restart
    slave_count[1] = 32'd16;
    clear_counts();
    exp_mem_q.push_back({32'h4800, 64'h5353_0001_0000_0010});
    start_op("abort", 1'b1, 32'h4800);
    begin
      int n = 0;
      while (!ssbus_read && n < 500) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("abort reached_read", 128'(ssbus_read), 128'(1));
    end
    reset = 1'b1;
    #1;
    check("abort async_clear", 128'({ssbus_read, mem_req, busy}), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_counts();
    push_img(32'h5000, 16);
    start_op("restart", 1'b1, 32'h5000);
    wait_end("restart");
    check("restart words", 128'(mem_wr_cnt), 128'(18));
    check("restart done_pulses", 128'(done_cnt), 128'(1));

    check("strobe one_hot", 128'(onehot_bad), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ss_master.md
# ss_master

Save-state bus initiator. On request it walks every save-state slave index in turn and produces a snapshot. In save mode it reads each slave's register words over ssbus and writes them, with headers, to a 64-bit memory port. In load mode it reads that image back and writes each word into the matching slave. It sits between the top-level save/load control logic and the ssbus fan-out that connects to every chip model in the design (priority mixer, tilemaps, sprites, and so on).

## Interface
Parameters:
- N_SLAVES, 32: number of slave indices walked, 0..N_SLAVES-1.
- TIMEOUT, 255: cycles to wait for a slave ack before giving up on that transaction.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start_save  in  1  one-cycle pulse that begins a save; honoured only in IDLE.
- start_load  in  1  one-cycle pulse that begins a load; honoured only in IDLE. If both pulse together, save wins.
- base_addr  in  32  byte address of the image, sampled at start.
- busy  out  1  high from start until DONE or ERR is reached.
- done  out  1  one-cycle pulse when the operation completes successfully.
- error  out  1  sticky; cleared by the next start.
- mem_addr  out  32  byte address; always 8-byte aligned.
- mem_wdata  out  64  write data.
- mem_req  out  1  request; held, with address and data stable, until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_ack  in  1  one-cycle completion; mem_rdata is valid in that cycle.
- mem_rdata  in  64  read data.
- ssbus  master  ssbus_if  fields: select[7:0], addr[23:0], data[63:0], query, read, write (master→slave); ack, data_out[63:0], count[31:0] (slave→master).

## Operation
- Image layout, per present slave: a header word {16'h5353, 8'h00, idx[7:0], count[31:0]}, then count data words. The image ends with a marker word 64'hFFFF_FFFF_FFFF_FFFF.
- A slave is "present" when its query ack returns count ≠ 0. An absent slave writes nothing to the image.
- Only one of query, read or write is high at any time. The strobe is held high, with select, addr and data stable, until ack or timeout. It drops in the cycle after ack.
- Save state sequence: IDLE → S_QUERY → (count=0 or timeout ? S_NEXT : S_HDR) → S_HDR (mem write of header) → S_RD (ssbus read of addr k) → S_WR (mem write of the captured data_out) → repeat S_RD for k+1 until k=count-1 → S_NEXT. S_NEXT increments idx. If idx=N_SLAVES it goes to S_END (mem write of marker), then DONE.
- Load state sequence: IDLE → L_HDR (mem read) → marker ? DONE. Otherwise check the header. Bad magic, idx ≥ N_SLAVES, or count > 2^24 → ERR. Otherwise → L_RD (mem read) → L_WR (ssbus write of the word to select=idx, addr=k) → repeat for each k → L_HDR.
- A timeout during S_RD or L_WR → ERR. A timeout during S_QUERY means the slave is absent and is not an error.
- mem_addr starts at base_addr and advances by 8 after every mem_ack. It wraps modulo 2^32.
- ERR: drop all strobes, set error, clear busy, then return to IDLE.
- DONE: pulse done, clear busy, then return to IDLE.
- Start pulses outside IDLE are ignored.

## Timing
- Reset values (async): every state register is IDLE; busy=0, done=0, error=0, mem_req=0, mem_we=0, query=0, read=0, write=0, select=0, addr=0, mem_addr=0, mem_wdata=0, ssbus.data=0.
- A start in cycle N raises busy in cycle N+1. The first strobe (query or mem_req) is also asserted in cycle N+1.
- ack received in cycle M:
  - the strobe is low in M+1;
  - the next strobe may rise in M+1 (no dead cycle required);
  - data_out and count are captured in cycle M.
- Timeout counter:
  - it resets whenever a new strobe rises;
  - timeout fires when the counter reaches TIMEOUT with ack still low;
  - an ack arriving in the same cycle as the timeout wins.
- mem_req has no timeout. The memory is assumed to always answer.
- If reset asserts mid-operation, all outputs go to their reset values immediately and no done pulse is produced.

## Test plan
- Save, N_SLAVES=4, slave 1 count=16 with data=addr*3, other slaves count=0 → memory holds header 64'h5353_0001_0000_0010, then 16 words 0,3,…,45, then the marker. Word count is 18. done pulses once.
- Load the image from the save test into a cleared slave 1 → ssbus writes addr 0..15 with data 0,3,…,45. Slave contents match the saved data. error=0.
- Slave 2 never acks its query (TIMEOUT=8) → slave 2 is skipped after 8 wait cycles. The save completes with error=0.
- Slave 1 acks its query with count=4 but never acks its read → error=1 and busy=0 after TIMEOUT cycles. No marker is written.
- Load with a header magic of 16'h1234 → error=1 after the first mem_ack. No ssbus write occurs.
- Assert reset while in S_RD with read high → read, mem_req and busy are 0 in the same cycle. A following start_save begins again at base_addr.
